// File: rtl/div_seq_unit.sv
// Iterative signed restoring divider with a start/busy/done handshake.
// Works on operand magnitudes for WIDTH steps, then applies the signs in a
// single fixup cycle. The quotient goes to ZLow and the remainder to ZHigh.
module div_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FIXUP,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH:0]   a_q, a_d;       // partial remainder, one guard bit
   logic [WIDTH-1:0] q_q, q_d;       // dividend magnitude shifting into quotient
   logic [WIDTH-1:0] m_q;            // divisor magnitude
   logic             sign_quot_q;
   logic             sign_rem_q;
   logic             busy_q, done_q, dbz_q;
   logic [WIDTH-1:0] quot_q, rem_q;

   logic [WIDTH:0]   a_shift, a_trial;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;

   // Operand magnitudes and the next restoring step, computed from current state.
   always_comb begin
      // NOTE: every signal gets a value on every path here, so no latch is inferred.
      dvd_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
      dvs_mag = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
      a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      a_trial = a_shift - {1'b0, m_q};
      if (a_trial[WIDTH]) begin
         a_d = a_shift;
         q_d = {q_q[WIDTH-2:0], 1'b0};
      end else begin
         a_d = a_trial;
         q_d = {q_q[WIDTH-2:0], 1'b1};
      end
   end

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (!Reset_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         a_q         <= '0;
         q_q         <= '0;
         m_q         <= '0;
         sign_quot_q <= 1'b0;
         sign_rem_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  if (Divisor != '0) begin
                     q_q         <= dvd_mag;
                     m_q         <= dvs_mag;
                     a_q         <= '0;
                     sign_quot_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                     sign_rem_q  <= Dividend[WIDTH-1];
                     count_q     <= CW'(WIDTH - 1);
                     busy_q      <= 1'b1;
                     state_q     <= S_ITER;
                  end else begin
                     // Divide by zero skips the datapath entirely.
                     quot_q  <= '1;
                     rem_q   <= Dividend;
                     dbz_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_ITER: begin
               a_q     <= a_d;
               q_q     <= q_d;
               count_q <= count_q - CW'(1);
               if (count_q == '0) begin
                  state_q <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               quot_q  <= sign_quot_q ? -q_q : q_q;
               rem_q   <= sign_rem_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
               dbz_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign DivByZero = dbz_q;
   assign Quotient  = quot_q;
   assign Remainder = rem_q;

endmodule

// File: doc/div_seq_unit.md
Name: div_seq_unit

Overview:
- Multi-cycle signed 32-bit divider for the phase-1 datapath ALU.
- It consumes the dividend from register Y and the divisor from the bus when the DIV control is pulsed.
- It produces the quotient for ZLow and the remainder for ZHigh.
- It replaces a combinational divide with an iterative restoring divider that has a start/busy/done handshake, so the control sequencer holds in T4 until Done.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 2)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset_n  input  1  reset, synchronous, active-low
Start  input  1  request; sampled only in IDLE
Dividend  input  WIDTH  signed dividend (Y register output)
Divisor  input  WIDTH  signed divisor (bus value)
Busy  output  1  high while an operation is in progress (ITER, FIXUP)
Done  output  1  one-cycle pulse when results are valid
DivByZero  output  1  set with Done when Divisor was 0; held with results
Quotient  output  WIDTH  signed quotient, to ZLow
Remainder  output  WIDTH  signed remainder, to ZHigh

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-low; Clock and Reset_n are as named in the port list.
  - Reset_n low at a rising edge gives: state=IDLE, Busy=0, Done=0, DivByZero=0, Quotient=0, Remainder=0, counter=0.
  - Reset applies in any state. An in-flight operation is abandoned and no Done is issued.
- States: IDLE, ITER, FIXUP, DONE.
- IDLE:
  - Start=1 with Divisor!=0:
    - Latch |Dividend| into the Q shift register and |Divisor| into M.
    - Clear the WIDTH+1-bit accumulator A.
    - Latch sign_q = Dividend[MSB]^Divisor[MSB] and sign_r = Dividend[MSB].
    - Counter=WIDTH-1. Go to ITER. Busy=1 from the next cycle.
  - Start=1 with Divisor==0: go to DONE directly.
    - Quotient = all ones.
    - Remainder = Dividend.
    - DivByZero=1.
  - Start=0: hold. Outputs keep their last values.
- ITER, one restoring step per edge:
  - {A,Q} shifted left 1.
  - A' = A - {0,M}.
  - If A' is negative: keep A, Q[0]=0. Otherwise: A=A', Q[0]=1.
  - Counter decrements. After the step with counter==0, go to FIXUP.
  - Exactly WIDTH iterations.
- FIXUP (one edge):
  - Quotient = sign_q ? -Q : Q.
  - Remainder = sign_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - DivByZero=0. Go to DONE.
- DONE (one cycle):
  - Done=1, Busy=0. Next edge returns to IDLE and Done=0.
  - Results and DivByZero hold until the next accepted Start or reset.
- Latency:
  - Done is high in the cycle after edge WIDTH+1, where edge 0 samples Start. For WIDTH=32 that is 33 edges.
  - Divide-by-zero: Done after edge 0 (1 edge).
- Arithmetic:
  - Matches Verilog signed / and %: truncation toward zero, remainder takes the dividend's sign, and Quotient*Divisor+Remainder==Dividend (mod 2^WIDTH).
  - Magnitudes use WIDTH-bit unsigned wrap, so -2^(WIDTH-1) is handled as magnitude 2^(WIDTH-1).
  - The overflow case -2^(WIDTH-1) / -1 yields Quotient=0x80000000 and Remainder=0. It is not flagged.
- Boundary conditions:
  - Start asserted in ITER, FIXUP or DONE is ignored and not queued. Start must be re-asserted in IDLE.
  - Start held high continuously starts a new operation on each IDLE visit. Back-to-back issue rate is one operation per WIDTH+3 edges.
  - Operand inputs are sampled only at the accepting edge. Later changes have no effect.
  - Reset_n low on the same edge as Start: reset wins.

Test Plan:
- Reset_n low 2 cycles, then high, idle -> Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0.
- Datapath load values: Dividend=0x00000022, Divisor=0x00000024, Start 1 cycle -> Done 33 edges later, Quotient=0x00000000, Remainder=0x00000022, Busy high for 32 ITER + 1 FIXUP cycles. Then Dividend=100, Divisor=7 -> Quotient=0x0000000E, Remainder=0x00000002.
- Signs:
  - -7/2 -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF.
  - 7/-2 -> Quotient=0xFFFFFFFD, Remainder=0x00000001.
  - -7/-2 -> Quotient=0x00000003, Remainder=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> Quotient=0x80000000, Remainder=0.
- Divisor=0, Dividend=0x00000026, Start -> Done one edge later, DivByZero=1, Quotient=0xFFFFFFFF, Remainder=0x00000026. The next valid divide clears DivByZero.
- Handshake: pulse Start again at iteration 10 with different operands -> ignored, and the original result is produced. Change Dividend/Divisor mid-operation -> no effect on the result.
- Reset mid-operation: Reset_n low at iteration 15 -> next edge all outputs 0, IDLE, no Done pulse. A new Start afterwards completes correctly with 33-edge latency.
